// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, arbiter state encoding and index helper
package uart_pkg;

  localparam int CLK_FREQ_HZ  = 100_000_000;
  localparam int DEFAULT_BAUD = 3_000_000;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_LOAD,
    ARB_ISSUE,
    ARB_WAIT_LOW,
    ARB_WAIT_HIGH
  } uart_arb_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after rr_ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        any = 1'b1;
        grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
        idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one uart_tx serializer
// Optional mid-packet stall release enabled by UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 10_000
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [NUM_REQ-1:0]   req_valid_in,
  input  logic [8*NUM_REQ-1:0] req_byte_in,
  input  logic [NUM_REQ-1:0]   req_last_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  output logic                 tx_valid_out,
  output logic [7:0]           tx_byte_out,
  input  logic                 tx_ready_in,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic                 pkt_done_out,
  output logic [IDX_W-1:0]     pkt_idx_out,
  output logic                 timeout_out
);

  uart_arb_state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [7:0]         hold_byte_q, hold_byte_d;
  logic               hold_last_q, hold_last_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   pidx_q, pidx_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req_valid_in),
    .rr_ptr (rr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    idx_d         = idx_q;
    rr_d          = rr_q;
    hold_byte_d   = hold_byte_q;
    hold_last_d   = hold_last_q;
    done_d        = 1'b0;
    pidx_d        = pidx_q;
    req_ready_out = '0;
    tx_valid_out  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    tmo_d         = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
          state_d = ARB_LOAD;
        end
      end
      ARB_LOAD: begin
        req_ready_out = grant_q & req_valid_in;
        if (req_valid_in[idx_q]) begin
          hold_byte_d = req_byte_in[{idx_q, 3'b000} +: 8];
          hold_last_d = req_last_in[idx_q];
          state_d     = ARB_ISSUE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Owner stalled too long mid-packet: drop it and let others in.
          tmo_d   = 1'b1;
          rr_d    = IDX_W'(wrap_inc(int'(idx_q), NUM_REQ));
          grant_d = '0;
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ARB_ISSUE: begin
        tx_valid_out = tx_ready_in;
        if (tx_ready_in) state_d = ARB_WAIT_LOW;
      end
      ARB_WAIT_LOW: begin
        if (!tx_ready_in) state_d = ARB_WAIT_HIGH;
      end
      ARB_WAIT_HIGH: begin
        if (tx_ready_in) begin
          if (hold_last_q) begin
            done_d  = 1'b1;
            pidx_d  = idx_q;
            rr_d    = IDX_W'(wrap_inc(int'(idx_q), NUM_REQ));
            grant_d = '0;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_LOAD;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
`ifdef UART_ARB_TIMEOUT_EN
    if (state_d == ARB_LOAD && state_q != ARB_LOAD) cnt_d = '0;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      idx_q       <= '0;
      rr_q        <= '0;
      hold_byte_q <= '0;
      hold_last_q <= 1'b0;
      done_q      <= 1'b0;
      pidx_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      hold_byte_q <= hold_byte_d;
      hold_last_q <= hold_last_d;
      done_q      <= done_d;
      pidx_q      <= pidx_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign timeout_out = tmo_q;
`else
  assign timeout_out = 1'b0;
`endif

  assign grant_out    = grant_q;
  assign tx_byte_out  = hold_byte_q;
  assign pkt_done_out = done_q;
  assign pkt_idx_out  = pidx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a behavioral serializer
module tb_uart_tx_arbiter;

  localparam int NR      = 4;
  localparam int BIT_CYC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_last = '0;
  logic [8*NR-1:0] req_byte = '0;
  logic [NR-1:0] req_ready;
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          tx_ready;
  logic [NR-1:0] grant;
  logic          pkt_done;
  logic [1:0]    pkt_idx;
  logic          timeout;

  int n_cmp = 0;
  int n_fail = 0;
  int n_tx_pulse = 0;
  int n_hs = 0;
  int n_tmo = 0;
  logic [7:0] obs_bytes[$];
  logic [7:0] rx_bytes[$];
  int         obs_done[$];

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .IDX_W          (2),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_valid_in  (req_valid),
    .req_byte_in   (req_byte),
    .req_last_in   (req_last),
    .req_ready_out (req_ready),
    .tx_valid_out  (tx_valid),
    .tx_byte_out   (tx_byte),
    .tx_ready_in   (tx_ready),
    .grant_out     (grant),
    .pkt_done_out  (pkt_done),
    .pkt_idx_out   (pkt_idx),
    .timeout_out   (timeout)
  );

  always #5 clk = ~clk;

  // Serializer model: ready drops the cycle after acceptance, 10 bits of BIT_CYC cycles each.
  logic       m_busy = 1'b0;
  logic       tx_line = 1'b1;
  logic [8:0] m_sh = '0;
  int         m_cyc = 0;
  int         m_bit = 0;
  assign tx_ready = ~m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      tx_line <= 1'b1;
      m_sh    <= '0;
      m_cyc   <= 0;
      m_bit   <= 0;
    end else if (!m_busy) begin
      if (tx_valid) begin
        m_busy  <= 1'b1;
        tx_line <= 1'b0;
        m_sh    <= {1'b1, tx_byte};
        m_cyc   <= 0;
        m_bit   <= 0;
      end
    end else if (m_cyc == BIT_CYC - 1) begin
      m_cyc <= 0;
      if (m_bit == 9) begin
        m_busy <= 1'b0;
      end else begin
        tx_line <= m_sh[0];
        m_sh    <= m_sh >> 1;
        m_bit   <= m_bit + 1;
      end
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  initial begin
    logic [7:0] r;
    forever begin
      @(negedge tx_line);
      repeat (BIT_CYC + BIT_CYC / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        r[i] = tx_line;
        if (i < 7) repeat (BIT_CYC) @(posedge clk);
      end
      rx_bytes.push_back(r);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (tx_valid && tx_ready) begin
          n_tx_pulse++;
          obs_bytes.push_back(tx_byte);
        end
        if (|(req_ready & req_valid)) n_hs++;
        if (pkt_done) obs_done.push_back(int'(pkt_idx));
        if (timeout) n_tmo++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic clear_obs();
    obs_bytes.delete();
    rx_bytes.delete();
    obs_done.delete();
  endtask

  task automatic send_byte(input int r, input logic [7:0] b, input logic last);
    bit ok = 1'b0;
    req_byte[8*r +: 8] = b;
    req_last[r]  = last;
    req_valid[r] = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      #1;
      if (req_ready[r]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL handshake_r%0d: ready never seen for byte %02h, required 1", r, b);
    end
  endtask

  task automatic send_pkt(input int r, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n);
    for (int i = 0; i < n; i++)
      send_byte(r, (i == 0) ? b0 : (i == 1) ? b1 : b2, i == n - 1);
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (obs_done.size() >= k) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_done: saw %0d packet completions, required %0d", obs_done.size(), k);
    end
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b, required 0000", grant); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
    n_cmp++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_done: got %b, required 0", pkt_done); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    clear_obs();
    req_byte[7:0] = 8'h55;
    req_last[0]   = 1'b1;
    req_valid[0]  = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL lat_idle_grant: got %b, required 0000", grant); end
    @(negedge clk); #1;
    n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL lat_load_grant: got %b, required 0001", grant); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL lat_load_ready: got %b, required 0001", req_ready); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL lat_load_tx_valid: got %b, required 0", tx_valid); end
    @(negedge clk); #1;
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL lat_issue_tx_valid: got %b, required 1", tx_valid); end
    n_cmp++; if (tx_byte !== 8'h55) begin n_fail++; $display("FAIL lat_issue_byte: got %02h, required 55", tx_byte); end
    @(negedge clk); #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL lat_one_pulse: got %b, required 0", tx_valid); end
    wait_done(1, 200);
    n_cmp++; if (obs_done.size() < 1 || obs_done[0] != 0) begin n_fail++; $display("FAIL lat_done_idx: got %0d entries, required idx 0", obs_done.size()); end
  endtask

  task automatic test_single();
    logic [23:0] got;
    clear_obs();
    send_pkt(0, 8'h41, 8'h42, 8'h43, 3);
    wait_done(1, 600);
    repeat (5) @(negedge clk);
    #1;
    got = (rx_bytes.size() == 3) ? {rx_bytes[0], rx_bytes[1], rx_bytes[2]} : 24'h0;
    n_cmp++; if (got !== 24'h414243) begin n_fail++; $display("FAIL single_line: got %06h (%0d frames), required 414243", got, rx_bytes.size()); end
    n_cmp++; if (obs_done.size() != 1) begin n_fail++; $display("FAIL single_done_count: got %0d, required 1", obs_done.size()); end
    n_cmp++; if (obs_done.size() < 1 || obs_done[0] != 0) begin n_fail++; $display("FAIL single_done_idx: required idx 0"); end
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_idle: got %b, required 0000", grant); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] got;
    clear_obs();
    fork
      send_pkt(1, 8'h11, 8'h12, 8'h00, 2);
      send_pkt(3, 8'h31, 8'h32, 8'h00, 2);
    join
    wait_done(2, 600);
    got = (obs_bytes.size() == 4) ? {obs_bytes[0], obs_bytes[1], obs_bytes[2], obs_bytes[3]} : 32'h0;
    n_cmp++; if (got !== 32'h11123132) begin n_fail++; $display("FAIL simul_order: got %08h, required 11123132", got); end
    n_cmp++; if (obs_done.size() != 2 || obs_done[0] != 1 || obs_done[1] != 3) begin n_fail++; $display("FAIL simul_done: got %0d entries, required idx 1 then 3", obs_done.size()); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] got;
    int          d;
    clear_obs();
    fork
      begin
        send_pkt(0, 8'hA0, 8'h00, 8'h00, 1);
        send_pkt(0, 8'hA1, 8'h00, 8'h00, 1);
        send_pkt(0, 8'hA2, 8'h00, 8'h00, 1);
      end
      begin
        send_pkt(2, 8'hC0, 8'h00, 8'h00, 1);
        send_pkt(2, 8'hC1, 8'h00, 8'h00, 1);
      end
    join
    wait_done(5, 800);
    got = (obs_bytes.size() == 5) ? {obs_bytes[0], obs_bytes[1], obs_bytes[2], obs_bytes[3], obs_bytes[4]} : 40'h0;
    n_cmp++; if (got !== 40'hA0C0A1C1A2) begin n_fail++; $display("FAIL b2b_order: got %010h, required a0c0a1c1a2", got); end
    d = 0;
    if (obs_done.size() == 5) d = obs_done[0] * 10000 + obs_done[1] * 1000 + obs_done[2] * 100 + obs_done[3] * 10 + obs_done[4];
    n_cmp++; if (d != 2020) begin n_fail++; $display("FAIL b2b_done_seq: got %05d, required 02020", d); end
  endtask

  task automatic test_stall();
    int          bad = 0;
    logic [23:0] got;
    clear_obs();
    send_byte(2, 8'h21, 1'b0);
    req_valid[2] = 1'b0;
    req_byte[7:0] = 8'h0F;
    req_last[0]   = 1'b1;
    req_valid[0]  = 1'b1;
    repeat (500) begin
      @(negedge clk); #1;
      if (tx_valid !== 1'b0 || grant !== 4'b0100) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d bad cycles, required 0", bad); end
    send_byte(2, 8'h22, 1'b1);
    req_valid[2] = 1'b0;
    req_last[2]  = 1'b0;
    send_byte(0, 8'h0F, 1'b1);
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    wait_done(2, 600);
    got = (obs_bytes.size() == 3) ? {obs_bytes[0], obs_bytes[1], obs_bytes[2]} : 24'h0;
    n_cmp++; if (got !== 24'h21220F) begin n_fail++; $display("FAIL stall_bytes: got %06h, required 21220f", got); end
    n_cmp++; if (obs_done.size() != 2 || obs_done[0] != 2 || obs_done[1] != 0) begin n_fail++; $display("FAIL stall_done: got %0d entries, required idx 2 then 0", obs_done.size()); end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    clear_obs();
    t0 = n_tmo;
    send_byte(1, 8'h51, 1'b0);
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    send_byte(2, 8'h52, 1'b1);
    req_valid[2] = 1'b0;
    req_last[2]  = 1'b0;
    wait_done(1, 600);
    n_cmp++; if (n_tmo - t0 != 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d, required 1", n_tmo - t0); end
    n_cmp++; if (obs_done.size() != 1 || obs_done[0] != 2) begin n_fail++; $display("FAIL timeout_next_owner: got %0d entries, required idx 2", obs_done.size()); end
  endtask
`endif

  task automatic test_conservation();
    n_cmp++; if (n_tx_pulse != n_hs) begin n_fail++; $display("FAIL conservation: %0d tx pulses, required %0d", n_tx_pulse, n_hs); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_pkt(1, 8'h61, 8'h00, 8'h00, 1);
    wait_done(1, 300);
    send_byte(2, 8'h62, 1'b1);
    req_valid[2] = 1'b0;
    req_last[2]  = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL rstmid_pre_grant: got %b, required 0100", grant); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant: got %b, required 0000", grant); end
    n_cmp++; if (tx_valid !== 1'b0 || pkt_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: tx_valid %b pkt_done %b, required 0 0", tx_valid, pkt_done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_obs();
    fork
      send_pkt(0, 8'hE0, 8'h00, 8'h00, 1);
      send_pkt(3, 8'hE3, 8'h00, 8'h00, 1);
    join
    wait_done(2, 400);
    n_cmp++; if (obs_done.size() != 2 || obs_done[0] != 0 || obs_done[1] != 3) begin n_fail++; $display("FAIL rstmid_first_winner: got %0d entries, required idx 0 then 3", obs_done.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_stall();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_conservation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
